// File: rtl/pci_bus_arbiter_pkg.sv
// Shared types and helpers for the PCI bus arbiter: FSM state encoding and width helper.
package pci_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    PARK_RST = 3'd0,
    PARK     = 3'd1,
    TURN     = 3'd2,
    GRANT    = 3'd3,
    BUSY     = 3'd4
  } arb_state_e;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// REQ#/GNT# pairs plus the FRAME#/IRDY# observation points shared by arbiter and initiators.
interface pci_bus_arbiter_if #(
  parameter int N_MASTERS = 4
);
  import pci_bus_arbiter_pkg::*;

  localparam int OW = clog2(N_MASTERS);

  logic [N_MASTERS-1:0] req_n;
  logic                 frame;
  logic                 IRDY;
  logic [N_MASTERS-1:0] gnt_n;
  logic [OW-1:0]        owner;
  logic                 bus_busy;
  logic                 timeout_ev;

  // The arbiter owns the grant side; initiators own requests and bus phases.
  modport master (
    input  req_n, frame, IRDY,
    output gnt_n, owner, bus_busy, timeout_ev
  );

  modport slave (
    output req_n, frame, IRDY,
    input  gnt_n, owner, bus_busy, timeout_ev
  );

endinterface

// File: rtl/pci_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, wrapping.
module pci_bus_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] index
);

  localparam logic [W:0] N_W = (W+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  assign dbl = {req, req};
  assign rot = dbl[start +: N];

  // Descending scan so the lowest rotated position wins.
  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = W'(k);
      end
    end
  end

  assign sum   = {1'b0, start} + {1'b0, off};
  assign index = (sum >= N_W) ? W'(sum - N_W) : sum[W-1:0];

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin REQ#/GNT# with parking, idle-bus turnaround and start timeout.
module pci_bus_arbiter
  import pci_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS     = 4,
  parameter int START_TIMEOUT = 16,
  parameter int PARK_DEFAULT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  pci_bus_arbiter_if.master  bus
);

  localparam int                   OW       = clog2(N_MASTERS);
  localparam int                   TW       = clog2(START_TIMEOUT + 1);
  localparam logic [OW-1:0]        PARK_IDX = OW'(PARK_DEFAULT);
  localparam logic [OW-1:0]        LAST_IDX = OW'(N_MASTERS - 1);
  localparam logic [TW-1:0]        TMO_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ALL_HIGH = '1;

  arb_state_e           state_reg, state_next;
  logic [OW-1:0]        owner_reg, owner_next;
  logic [N_MASTERS-1:0] gnt_n_reg, gnt_n_next;
  logic [TW-1:0]        tmo_cnt_reg, tmo_cnt_next;
  logic                 timeout_ev_reg, timeout_ev_next;
  logic                 bus_busy_reg;

  logic                 idle;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] other_vec;
  logic                 own_req, others_req, hold_gnt;
  logic [OW-1:0]        pick_start, pick_index;
  logic                 pick_valid;

  function automatic logic [N_MASTERS-1:0] grant_on(input logic [OW-1:0] idx);
    logic [N_MASTERS-1:0] g;
    g      = '1;
    g[idx] = 1'b0;
    return g;
  endfunction

  assign idle    = bus.frame & bus.IRDY;
  assign req     = ~bus.req_n;
  assign own_req = req[owner_reg];

  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_other
      assign other_vec[gi] = req[gi] & (owner_reg != OW'(gi));
    end
  endgenerate

  assign others_req = |other_vec;
  // A grant survives a transfer only while it is already held and uncontested.
  assign hold_gnt   = own_req & ~others_req & ~gnt_n_reg[owner_reg];
  assign pick_start = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;

  pci_bus_arbiter_rr_pick #(
    .N (N_MASTERS),
    .W (OW)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .valid (pick_valid),
    .index (pick_index)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= PARK_RST;
      owner_reg      <= PARK_IDX;
      gnt_n_reg      <= ALL_HIGH;
      tmo_cnt_reg    <= '0;
      timeout_ev_reg <= 1'b0;
      bus_busy_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      gnt_n_reg      <= gnt_n_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      timeout_ev_reg <= timeout_ev_next;
      bus_busy_reg   <= ~idle;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PARK_RST: state_next = PARK;
      PARK: begin
        if (!idle)                        state_next = BUSY;
        else if (!own_req && others_req)  state_next = TURN;
      end
      TURN:     state_next = pick_valid ? GRANT : PARK;
      GRANT: begin
        if (!idle)                        state_next = BUSY;
        else if (!own_req)                state_next = others_req ? TURN : PARK;
        else if (tmo_cnt_reg == TMO_LAST) state_next = TURN;
      end
      BUSY: begin
        if (idle) begin
          if (others_req)                 state_next = TURN;
          else if (own_req)               state_next = GRANT;
          else                            state_next = PARK;
        end
      end
      default:                            state_next = PARK_RST;
    endcase
  end

  // Registered outputs are derived from the transition being taken this edge.
  always_comb begin
    owner_next      = owner_reg;
    gnt_n_next      = ALL_HIGH;
    tmo_cnt_next    = '0;
    timeout_ev_next = 1'b0;
    case (state_next)
      PARK: begin
        if (state_reg == PARK_RST) owner_next = PARK_IDX;
        gnt_n_next = grant_on(owner_next);
      end
      GRANT: begin
        if (state_reg == TURN)  owner_next   = pick_index;
        if (state_reg == GRANT) tmo_cnt_next = tmo_cnt_reg + 1'b1;
        gnt_n_next = grant_on(owner_next);
      end
      BUSY:  gnt_n_next = hold_gnt ? grant_on(owner_reg) : ALL_HIGH;
      TURN:  timeout_ev_next = (state_reg == GRANT) && idle && own_req &&
                               (tmo_cnt_reg == TMO_LAST);
      default: gnt_n_next = ALL_HIGH;
    endcase
  end

  assign bus.gnt_n      = gnt_n_reg;
  assign bus.owner      = owner_reg;
  assign bus.bus_busy   = bus_busy_reg;
  assign bus.timeout_ev = timeout_ev_reg;

endmodule
